// File: rtl/stochastic_mux_adder_n.sv
// stochastic_mux_adder_n: N-input stochastic adder, LFSR-driven MUX or OR.
// Consumes BIT_LENGTH beats per run and counts output ones.
module stochastic_mux_adder_n #(
    parameter int          N_IN       = 4,
    parameter int          BIT_LENGTH = 128,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    localparam int         SEL_W      = $clog2(N_IN),
    localparam int         CNT_W      = $clog2(BIT_LENGTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             mode_i,
    input  logic [N_IN-1:0]  in_bits_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic             y_o,
    output logic             y_valid_o,
    output logic [SEL_W-1:0] sel_out_o,
    output logic [CNT_W-1:0] ones_count_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    logic [1:0]       state_q, state_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] ones_q, ones_d;
    logic             mode_q, mode_d;
    logic             y_q, y_d;
    logic             y_valid_q, y_valid_d;
    logic [SEL_W-1:0] sel_q, sel_d;

    logic [SEL_W-1:0] sel;
    logic             y_comb;
    logic             lfsr_fb;

    assign sel     = lfsr_q[SEL_W-1:0];
    assign y_comb  = mode_q ? (|in_bits_i) : in_bits_i[sel];
    assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    // Next-state: run control, beat acceptance, LFSR step and counting
    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        bit_cnt_d = bit_cnt_q;
        ones_d    = ones_q;
        mode_d    = mode_q;
        y_d       = y_q;
        y_valid_d = 1'b0;
        sel_d     = sel_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d   = S_RUN;
                    lfsr_d    = LFSR_SEED;
                    bit_cnt_d = '0;
                    ones_d    = '0;
                    mode_d    = mode_i;
                end
            end
            S_RUN: begin
                if (in_valid_i) begin
                    y_d       = y_comb;
                    y_valid_d = 1'b1;
                    sel_d     = sel;
                    ones_d    = ones_q + CNT_W'(y_comb);
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    lfsr_d    = {lfsr_q[14:0], lfsr_fb};
                    if (bit_cnt_q == CNT_W'(BIT_LENGTH - 1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any run without a done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            lfsr_q    <= LFSR_SEED;
            bit_cnt_q <= '0;
            ones_q    <= '0;
            mode_q    <= 1'b0;
            y_q       <= 1'b0;
            y_valid_q <= 1'b0;
            sel_q     <= '0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            bit_cnt_q <= bit_cnt_d;
            ones_q    <= ones_d;
            mode_q    <= mode_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            sel_q     <= sel_d;
        end
    end

    assign in_ready_o   = (state_q == S_RUN);
    assign busy_o       = (state_q == S_RUN);
    assign done_o       = (state_q == S_DONE);
    assign y_o          = y_q;
    assign y_valid_o    = y_valid_q;
    assign sel_out_o    = sel_q;
    assign ones_count_o = ones_q;

endmodule

// File: tb/tb_stochastic_mux_adder_n.sv
// tb_stochastic_mux_adder_n: scoreboard bench for stochastic_mux_adder_n.
// Expected y/sel are queued at drive time and popped on y_valid.
module tb_stochastic_mux_adder_n;

    localparam int          N    = 4;
    localparam int          BL   = 128;
    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_i = 1'b0;
    logic       mode_i = 1'b0;
    logic [3:0] in_bits_i = '0;
    logic       in_valid_i = 1'b0;
    logic       in_ready_o;
    logic       y_o;
    logic       y_valid_o;
    logic [1:0] sel_out_o;
    logic [7:0] ones_count_o;
    logic       busy_o;
    logic       done_o;

    stochastic_mux_adder_n #(
        .N_IN(N), .BIT_LENGTH(BL), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .start_i(start_i), .mode_i(mode_i),
        .in_bits_i(in_bits_i), .in_valid_i(in_valid_i),
        .in_ready_o(in_ready_o), .y_o(y_o),
        .y_valid_o(y_valid_o), .sel_out_o(sel_out_o),
        .ones_count_o(ones_count_o), .busy_o(busy_o),
        .done_o(done_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       y;
        logic [1:0] sel;
    } exp_t;

    int         total = 0;
    int         bad = 0;
    exp_t       exp_q[$];
    bit         ycap[$];
    bit         saved[$];
    logic [3:0] stream[BL];
    logic [3:0] rnd[BL];
    logic [15:0] mlfsr;
    int         mones;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // Monitor: pop expectation on every output beat
    always @(posedge clk) begin
        #1;
        if (y_valid_o) begin
            if (exp_q.size() == 0) begin
                chk("spurious_yv", 32'(y_valid_o), 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("y", 32'(y_o), 32'(e.y));
                chk("sel", 32'(sel_out_o), 32'(e.sel));
                ycap.push_back(y_o);
            end
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk(tag, {in_ready_o, y_o, y_valid_o, sel_out_o,
                  ones_count_o, busy_o, done_o}, 0);
    endtask

    // Caller sits at a negedge; start is driven immediately
    task automatic run(input bit m, input bit stall, input int abort_at,
                       input bit poke, output int cyc);
        int i;
        ycap.delete();
        start_i = 1'b1;
        mode_i  = m;
        @(negedge clk);
        start_i = 1'b0;
        mode_i  = ~m;
        mlfsr = SEED;
        mones = 0;
        chk("busy_run", 32'(busy_o), 1);
        i = 0;
        cyc = 0;
        while (i < BL && cyc < 1000) begin
            start_i = (poke && i == 50);
            if (i == abort_at) begin
                in_valid_i = 1'b0;
                rst_n = 1'b0;
                #1;
                chk_reset_vals("abort_rst");
                chk("abort_q", exp_q.size(), 0);
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                return;
            end
            if (stall && cyc[0]) begin
                in_valid_i = 1'b0;
                in_bits_i  = 4'($urandom);
            end else begin
                logic [1:0] s;
                logic       yb;
                exp_t       e;
                in_valid_i = 1'b1;
                in_bits_i  = stream[i];
                s  = mlfsr[1:0];
                yb = m ? (|stream[i]) : stream[i][s];
                chk("rdy", 32'(in_ready_o), 1);
                e.y = yb;
                e.sel = s;
                exp_q.push_back(e);
                mones += int'(yb);
                mlfsr = lfsr_step(mlfsr);
                i++;
            end
            @(negedge clk);
            cyc++;
        end
        start_i = 1'b0;
        in_valid_i = 1'b0;
        if (i < BL) chk("timeout", 0, 1);
        chk("done", 32'(done_o), 1);
        chk("rdy_done", 32'(in_ready_o), 0);
        chk("ones", 32'(ones_count_o), 32'(mones));
        if (poke) start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        chk("done_pulse", {done_o, busy_o}, 0);
        chk("ones_hold", 32'(ones_count_o), 32'(mones));
        chk("q_empty", exp_q.size(), 0);
    endtask

    task automatic cmp_saved(input string tag);
        int diff;
        diff = 0;
        if (ycap.size() != saved.size()) diff = 1000;
        else foreach (ycap[k]) if (ycap[k] != saved[k]) diff++;
        chk(tag, diff, 0);
    endtask

    initial begin
        int cyc;
        int ref_ones;
        foreach (rnd[k]) rnd[k] = 4'($urandom);

        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);

        foreach (stream[k]) stream[k] = 4'b1111;
        run(1'b0, 1'b0, -1, 1'b0, cyc);
        chk("all_ones", 32'(mones), 128);
        chk("all_ones_n", ycap.size(), BL);

        foreach (stream[k]) stream[k] = 4'b0001;
        run(1'b0, 1'b0, -1, 1'b0, cyc);

        foreach (stream[k]) stream[k] = 4'b0000;
        run(1'b1, 1'b0, -1, 1'b0, cyc);
        chk("or_zero", 32'(mones), 0);

        foreach (stream[k]) stream[k] = 4'b0010;
        run(1'b1, 1'b0, -1, 1'b0, cyc);
        chk("or_full", 32'(mones), 128);

        foreach (stream[k]) stream[k] = rnd[k];
        run(1'b0, 1'b0, -1, 1'b0, cyc);
        saved = ycap;
        ref_ones = mones;

        run(1'b0, 1'b1, -1, 1'b0, cyc);
        cmp_saved("stall_y");
        chk("stall_ones", 32'(mones), 32'(ref_ones));
        chk("stall_cyc", cyc, 2 * BL - 1);

        run(1'b0, 1'b0, -1, 1'b1, cyc);
        cmp_saved("poke_y");

        run(1'b0, 1'b0, -1, 1'b0, cyc);
        cmp_saved("b2b_y");

        in_valid_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_yv", {y_valid_o, busy_o}, 0);
        end
        in_valid_i = 1'b0;

        foreach (stream[k]) stream[k] = 4'($urandom);
        run(1'b1, 1'b0, 50, 1'b0, cyc);
        foreach (stream[k]) stream[k] = rnd[k];
        run(1'b0, 1'b0, -1, 1'b0, cyc);
        cmp_saved("repro_y");

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
